// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory shared by fetch and load/store.
// Grants one access at a time and waits out the fixed memory latency.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   ifReq/ifAddr    fetch request in; ifGnt/ifRvalid/ifRdata out
//   dReq/dWe/dAddr  data request in, with dWdata/dByteEn
//   dGnt/dRvalid    data grant and completion; dRdata load data
//   mem*            memory strobe/address/data out, memRdata in
//   busy            access in flight
//   ifGrantCnt, dGrantCnt, conflictCnt
//                   perf counters, live only with MEM_ARB_PERF_CNT_EN
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifGnt,
  output logic              ifRvalid,
  output logic [DATA_W-1:0] ifRdata,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  input  logic [3:0]        dByteEn,
  output logic              dGnt,
  output logic              dRvalid,
  output logic [DATA_W-1:0] dRdata,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic [3:0]        memByteEn,
  input  logic [DATA_W-1:0] memRdata,
  output logic              busy,
  output logic [31:0]       ifGrantCnt,
  output logic [31:0]       dGrantCnt,
  output logic [31:0]       conflictCnt
);

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              own_q, own_d;
  logic [DATA_W-1:0] ifrd_q, drd_q;

  logic idle;
  logic force_if;
  logic win_if;
  logic win_d;
  logic done;

  // Gating with rst keeps every output low while reset is held,
  // even though the Mealy grant path sees live requests.
  always_comb begin
    idle     = rst && (state_q == IDLE);
    force_if = ifReq && (starve_q == LIM);
    win_d    = idle && dReq && !force_if;
    win_if   = idle && ifReq && !win_d;
    done     = rst && (state_q == WAIT)
               && (cnt_q == 4'd1);
  end

  always_comb begin
    ifGnt     = 1'b0;
    dGnt      = 1'b0;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWdata  = '0;
    memByteEn = 4'h0;
    unique case (1'b1)
      win_d: begin
        dGnt      = 1'b1;
        memReq    = 1'b1;
        memWe     = dWe;
        memAddr   = dAddr;
        memWdata  = dWdata;
        memByteEn = dByteEn;
      end
      win_if: begin
        ifGnt     = 1'b1;
        memReq    = 1'b1;
        memAddr   = ifAddr;
        memByteEn = 4'hF;
      end
      default: ;
    endcase
  end

  always_comb begin
    ifRvalid = done && !own_q;
    dRvalid  = done && own_q;
    ifRdata  = ifRvalid ? memRdata : ifrd_q;
    dRdata   = dRvalid ? memRdata : drd_q;
    busy     = rst && (state_q == WAIT);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    own_d    = own_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (win_if || win_d) begin
          state_d = WAIT;
          cnt_d   = LAT;
          own_d   = win_d;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Only D grants taken while fetch waits count as starvation.
    if (win_if) begin
      starve_d = 4'd0;
    end else if (win_d && ifReq
                 && starve_q != LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      starve_q <= 4'd0;
      own_q    <= 1'b0;
      ifrd_q   <= '0;
      drd_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      own_q    <= own_d;
      if (ifRvalid) begin
        ifrd_q <= memRdata;
      end
      if (dRvalid) begin
        drd_q <= memRdata;
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] ifc_q, dc_q, cc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifc_q <= 32'd0;
      dc_q  <= 32'd0;
      cc_q  <= 32'd0;
    end else begin
      if (win_if) begin
        ifc_q <= ifc_q + 32'd1;
      end
      if (win_d) begin
        dc_q <= dc_q + 32'd1;
      end
      if (idle && ifReq && dReq) begin
        cc_q <= cc_q + 32'd1;
      end
    end
  end

  assign ifGrantCnt  = ifc_q;
  assign dGrantCnt   = dc_q;
  assign conflictCnt = cc_q;
`else
  assign ifGrantCnt  = 32'h0;
  assign dGrantCnt   = 32'h0;
  assign conflictCnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with response scoreboard.
// Expected completions are queued at issue, popped on rvalid.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifGnt, ifRvalid;
  logic [31:0] ifRdata;
  logic        dReq, dWe;
  logic [31:0] dAddr, dWdata;
  logic [3:0]  dByteEn;
  logic        dGnt, dRvalid;
  logic [31:0] dRdata;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memByteEn;
  logic [31:0] memRdata;
  logic        busy;
  logic [31:0] ifGrantCnt, dGrantCnt, conflictCnt;

`ifdef MEM_ARB_PERF_CNT_EN
  localparam logic [31:0] PEXP = 32'd2;
`else
  localparam logic [31:0] PEXP = 32'd0;
`endif

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr),
    .ifGnt(ifGnt), .ifRvalid(ifRvalid),
    .ifRdata(ifRdata),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr),
    .dWdata(dWdata), .dByteEn(dByteEn),
    .dGnt(dGnt), .dRvalid(dRvalid),
    .dRdata(dRdata),
    .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata),
    .memByteEn(memByteEn), .memRdata(memRdata),
    .busy(busy),
    .ifGrantCnt(ifGrantCnt),
    .dGrantCnt(dGrantCnt),
    .conflictCnt(conflictCnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_d;
    bit          dc;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: two-cycle read pipe, matching MEM_LATENCY=2.
  logic [31:0] p1 = 32'h0, p2 = 32'h0;
  always @(posedge clk) begin
    p1 <= memReq ? rd(memAddr) : 32'h0;
    p2 <= p1;
  end
  assign memRdata = p2;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  task automatic push(input bit is_d, input bit dc,
                      input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.dc   = dc;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst && (ifRvalid || dRvalid)) begin
      if (ifRvalid && dRvalid) begin
        chk("rvalid_both", {ifRvalid, dRvalid}, 0);
      end else if (sbq.size() == 0) begin
        chk("rvalid_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_port", dRvalid, e.is_d);
        if (!e.dc) begin
          chk("sb_data", e.is_d ? dRdata : ifRdata,
              e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected done");
    $fatal(1, "timeout");
  end

  task automatic scen2();
    nxt();
    ifReq = 1; ifAddr = 32'h104;
    dReq = 1; dWe = 0; dAddr = 32'h200;
    dByteEn = 4'hF;
    push(1, 0, rd(32'h200));
    push(0, 0, rd(32'h104));
    smp();
    chk("s2_gnt", {ifGnt, dGnt}, 2'b01);
    chk("s2_daddr", memAddr, 32'h200);
    chk("s2_dwe", memWe, 0);
    nxt();
    dReq = 0; dAddr = 0; dByteEn = 0;
    smp();
    chk("s2_wait_nognt", {ifGnt, dGnt}, 0);
    nxt(); smp();
    chk("s2_drvalid", dRvalid, 1);
    nxt(); smp();
    chk("s2_ifgnt", ifGnt, 1);
    chk("s2_ifaddr", memAddr, 32'h104);
    chk("s2_ifbe", memByteEn, 4'hF);
    nxt();
    ifReq = 0; ifAddr = 0;
    smp();
    nxt(); smp();
    chk("s2_ifrvalid", ifRvalid, 1);
    nxt(); smp();
    chk("s2_idle", busy, 0);
  endtask

  initial begin
    rst = 0; ifReq = 0; ifAddr = 0;
    dReq = 0; dWe = 0; dAddr = 0;
    dWdata = 0; dByteEn = 0;
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_memreq", memReq, 0);
    chk("rst_ifrdata", ifRdata, 0);
    chk("rst_drdata", dRdata, 0);
    chk("rst_perf", ifGrantCnt | dGrantCnt
        | conflictCnt, 0);
    nxt();
    rst = 1;
    smp();
    chk("noreq_memreq", memReq, 0);
    chk("noreq_addr", memAddr, 0);

    // Lone fetch
    nxt();
    ifReq = 1; ifAddr = 32'h100;
    push(0, 0, 32'h00500093);
    smp();
    chk("t1_ifgnt", ifGnt, 1);
    chk("t1_memreq", memReq, 1);
    chk("t1_addr", memAddr, 32'h100);
    chk("t1_we", memWe, 0);
    chk("t1_be", memByteEn, 4'hF);
    chk("t1_busy0", busy, 0);
    nxt();
    ifReq = 0; ifAddr = 0;
    smp();
    chk("t1_busy1", busy, 1);
    chk("t1_memreq_off", memReq, 0);
    chk("t1_addr_off", memAddr, 0);
    nxt(); smp();
    chk("t1_rvalid", ifRvalid, 1);
    chk("t1_rdata", ifRdata, 32'h00500093);
    chk("t1_busy2", busy, 1);
    nxt(); smp();
    chk("t1_done", {busy, ifRvalid}, 0);
    chk("t1_hold", ifRdata, 32'h00500093);

    scen2();

    // Starvation: D,D,D,D,IF repeating, grant every 3 cycles
    nxt();
    ifReq = 1; ifAddr = 32'h108;
    dReq = 1; dWe = 0; dAddr = 32'h300;
    dByteEn = 4'hF;
    for (int g = 0; g < 10; g++) begin
      if (g % 5 == 4) push(0, 0, rd(32'h108));
      else push(1, 0, rd(32'h300));
    end
    for (int k = 0; k < 30; k++) begin
      logic [1:0] eg;
      if (k > 0) nxt();
      smp();
      eg = 2'b00;
      if (k % 3 == 0) begin
        eg = ((k / 3) % 5 == 4) ? 2'b10 : 2'b01;
      end
      chk($sformatf("t3_gnt_c%0d", k),
          {ifGnt, dGnt}, eg);
    end
    nxt();
    ifReq = 0; dReq = 0; ifAddr = 0; dAddr = 0;
    smp();
    chk("t3_idle", busy, 0);

    // Store
    nxt();
    dReq = 1; dWe = 1; dAddr = 32'h40;
    dWdata = 32'hDEADBEEF; dByteEn = 4'b0011;
    push(1, 1, 32'h0);
    smp();
    chk("t4_dgnt", dGnt, 1);
    chk("t4_we", memWe, 1);
    chk("t4_addr", memAddr, 32'h40);
    chk("t4_wdata", memWdata, 32'hDEADBEEF);
    chk("t4_be", memByteEn, 4'b0011);
    nxt();
    dReq = 0; dWe = 0; dAddr = 0;
    dWdata = 0; dByteEn = 0;
    smp();
    nxt(); smp();
    chk("t4_drvalid", dRvalid, 1);
    chk("t4_ifrvalid", ifRvalid, 0);
    nxt(); smp();

    // Reset in WAIT kills the access
    nxt();
    ifReq = 1; ifAddr = 32'h10C;
    smp();
    chk("t5_gnt", ifGnt, 1);
    nxt();
    ifReq = 0;
    smp();
    chk("t5_wait", busy, 1);
    #1;
    rst = 0;
    ifReq = 1; ifAddr = 32'h110;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_req", {memReq, ifGnt, dGnt}, 0);
    chk("t5_rst_addr", memAddr, 0);
    chk("t5_rst_ifrd", ifRdata, 0);
    chk("t5_rst_drd", dRdata, 0);
    nxt(); smp();
    chk("t5_no_rvalid", {ifRvalid, dRvalid}, 0);
    nxt();
    rst = 1;
    push(0, 0, rd(32'h110));
    smp();
    chk("t5_regnt", ifGnt, 1);
    chk("t5_readdr", memAddr, 32'h110);
    nxt();
    ifReq = 0; ifAddr = 0;
    smp();
    nxt(); smp();
    chk("t5_rvalid", ifRvalid, 1);
    nxt(); smp();

    // Perf counters over two runs of the conflict case
    nxt();
    rst = 0;
    smp();
    chk("t6_clr", ifGrantCnt | dGrantCnt
        | conflictCnt, 0);
    nxt();
    rst = 1;
    smp();
    scen2();
    scen2();
    chk("t6_ifcnt", ifGrantCnt, PEXP);
    chk("t6_dcnt", dGrantCnt, PEXP);
    chk("t6_ccnt", conflictCnt, PEXP);

    repeat (4) nxt();
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the fetch stage (IF port) and the load/store path (D port, driven by control memControl decode).
- Runs a grant/wait/complete state machine and provides starvation protection for fetch.
- Sits between the cpu top-level fetch/LSU logic and the memory model.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LATENCY, 2, cycles from memReq to valid memRdata; legal range 1..15.
- STARVE_LIMIT, 4, consecutive D grants while ifReq is pending before IF is forced to win; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- ifReq  input  1  fetch request; held high until ifGnt
- ifAddr  input  ADDR_W  fetch address
- ifGnt  output  1  one-cycle grant pulse to fetch
- ifRvalid  output  1  one-cycle pulse; ifRdata valid
- ifRdata  output  DATA_W  fetched instruction
- dReq  input  1  data request; held until dGnt
- dWe  input  1  1 = store, 0 = load
- dAddr  input  ADDR_W  data address
- dWdata  input  DATA_W  store data
- dByteEn  input  4  byte lanes
- dGnt  output  1  one-cycle grant pulse to data
- dRvalid  output  1  one-cycle completion pulse (load data or store ack)
- dRdata  output  DATA_W  load data
- memReq  output  1  memory access strobe, one cycle
- memWe  output  1  memory write enable
- memAddr  output  ADDR_W  memory address
- memWdata  output  DATA_W  memory write data
- memByteEn  output  4  memory byte lanes
- memRdata  input  DATA_W  memory read data
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- States: IDLE, WAIT.
- Reset (rst low, async): state = IDLE; latency counter = 0; owner = IF; starveCnt = 0.
- All outputs are 0 during reset; ifRdata and dRdata also read 0.
- Pending memory responses are discarded and no rvalid is emitted for them.

IDLE, Mealy grant:
- In the same cycle, the winner's gnt = 1 and memReq = 1.
- memAddr, memWe, memWdata and memByteEn are driven from the winner.
- If the IF port wins: memWe = 0, memByteEn = 4'hF.
- At the clock edge: owner is latched, counter is loaded with MEM_LATENCY, and the FSM goes to WAIT.

Arbitration with both requests high:
- D wins unless starveCnt == STARVE_LIMIT, in which case IF wins.
- A single requester always wins.
- With no request, all strobes stay 0.

starveCnt:
- Increments, saturating at STARVE_LIMIT, on each D grant issued while ifReq = 1.
- Clears to 0 on any IF grant.
- Otherwise holds.

WAIT:
- Counter decrements each cycle.
- In the cycle where the counter == 1 (i.e. the cycle at memReq cycle + MEM_LATENCY), the owner's rvalid = 1 and rdata = memRdata (passthrough).
- For a store, dRvalid = 1 and dRdata = memRdata, which is don't-care.
- At that edge the FSM returns to IDLE.
- No grant is issued in WAIT; the next grant comes at the earliest in the following IDLE cycle.
- Throughput is one access per MEM_LATENCY+1 cycles.

Output defaults and other rules:
- memReq, gnt and rvalid are 0 in every cycle not listed above.
- mem* data/address outputs are 0 when memReq = 0.
- rdata outputs hold their last delivered value.
- Requests that drop before their grant are simply not served; no error is raised.
- Address and data bus widths pass through unmodified; no alignment checks are made.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, three 32-bit outputs are added:
  - ifGrantCnt: counts IF grants.
  - dGrantCnt: counts D grants.
  - conflictCnt: counts IDLE cycles with ifReq and dReq both high.
- The counters wrap 32'hFFFF_FFFF -> 0 and are cleared by rst.
- When undefined, the ports still exist but are tied to 32'h0, and no counter flops are inferred.

Test Plan:
1. Lone fetch (MEM_LATENCY=2): ifReq=1, ifAddr=0x100 at cycle 0.
   - Cycle 0: ifGnt=1, memReq=1, memAddr=0x100, memWe=0, memByteEn=F.
   - Cycle 2: ifRvalid=1, ifRdata=memRdata=0x00500093.
   - busy is high for cycles 1-2.
2. Simultaneous requests: ifReq and dReq (load, 0x200) both high at cycle 0.
   - dGnt at cycle 0, dRvalid at cycle 2.
   - ifGnt at cycle 3, ifRvalid at cycle 5.
3. Starvation (STARVE_LIMIT=4): dReq and ifReq held high continuously.
   - Grant sequence is D, D, D, D, IF, D..., with a grant every 3 cycles.
   - starveCnt returns to 0 after the IF grant.
4. Store: dReq=1, dWe=1, dAddr=0x40, dWdata=0xDEADBEEF, dByteEn=4'b0011.
   - memWe=1 with those values in the grant cycle.
   - dRvalid=1 two cycles later; ifRvalid stays 0.
5. Reset mid-operation: assert rst low in WAIT cycle 1.
   - All outputs 0 immediately (asynchronously); no rvalid follows.
   - After release, a fresh ifReq is granted in the first IDLE cycle.
6. With MEM_ARB_PERF_CNT_EN defined: run scenario 2 twice.
   - ifGrantCnt=2, dGrantCnt=2, conflictCnt=2.
   - Without the macro, all three outputs read 0.
